// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor:
// 2-bit counter encoding, predictor modes, counter update and table indexing.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MODE_BIMODAL = 32'sd0;
  localparam int MODE_GSHARE  = 32'sd1;

  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    case (c)
      SNT:     r = taken ? WNT : SNT;
      WNT:     r = taken ? WT  : SNT;
      WT:      r = taken ? ST  : WNT;
      ST:      r = taken ? ST  : WT;
      default: r = WNT;
    endcase
    return r;
  endfunction

  // pc_word is the PC already shifted right by two; the caller truncates to IDX bits.
  function automatic logic [31:0] bp_index(input logic [31:0] pc_word,
                                           input logic [31:0] ghr,
                                           input logic        gshare);
    logic [31:0] r;
    if (gshare) begin
      r = pc_word ^ ghr;
    end else begin
      r = pc_word;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: one combinational lookup port,
// one write port, and a per-entry valid clear used by the initialisation sweep.
module bp_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic                       clk,
  input  logic [XLEN-3:0]            lk_pc_word,
  output logic                       lk_hit,
  output logic [XLEN-1:0]            lk_target,
  input  logic                       wr_en,
  input  logic [XLEN-3:0]            wr_pc_word,
  input  logic [XLEN-1:0]            wr_target,
  input  logic                       clr_en,
  input  logic [$clog2(ENTRIES)-1:0] clr_idx
);

  localparam int BIDX = $clog2(ENTRIES);
  localparam int TW   = XLEN - BIDX - 2;

  logic            valid_q  [ENTRIES];
  logic [TW-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];

  logic [BIDX-1:0] lk_idx;
  logic [BIDX-1:0] wr_idx;

  // Lookup reads stored state only, so a same-cycle write is seen next cycle.
  always_comb begin
    lk_idx    = lk_pc_word[BIDX-1:0];
    wr_idx    = wr_pc_word[BIDX-1:0];
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_pc_word[XLEN-3:BIDX]);
    lk_target = target_q[lk_idx];
  end

  // Table storage; the sweep clear takes priority over a resolve write.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_pc_word[XLEN-3:BIDX];
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/bp_gshare_predictor.sv
// Fetch-stage direction/target predictor (gshare or bimodal) with speculative
// global history, mispredict repair, flush/redirect generation and statistics.
module bp_gshare_predictor
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int BTB_ENTRIES = 64,
  parameter int MODE        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_valid,
  input  logic [XLEN-1:0]     f_pc,
  output logic                f_pred_taken,
  output logic [XLEN-1:0]     f_pred_target,
  output logic [GHR_BITS-1:0] f_ghr,
  input  logic                ex_valid,
  input  logic                ex_is_branch,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic                ex_taken,
  input  logic [XLEN-1:0]     ex_target,
  input  logic                ex_pred_taken,
  input  logic [XLEN-1:0]     ex_pred_target,
  input  logic [GHR_BITS-1:0] ex_ghr,
  output logic                ready,
  output logic                flush,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
);

  localparam int   IDX        = $clog2(BHT_ENTRIES);
  localparam int   BIDX       = $clog2(BTB_ENTRIES);
  localparam int   SWEEP      = (BHT_ENTRIES > BTB_ENTRIES) ? BHT_ENTRIES : BTB_ENTRIES;
  localparam int   SW         = $clog2(SWEEP);
  localparam logic USE_GSHARE = (MODE == MODE_GSHARE);

  state_t              state_q, state_d;
  logic [SW-1:0]       sweep_idx_q, sweep_idx_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_branches_q, stat_branches_d;
  logic [31:0]         stat_mispred_q, stat_mispred_d;
  ctr_t                bht_q [BHT_ENTRIES];

  logic                run;
  logic                resolve;
  logic                mispred;
  logic [IDX-1:0]      f_idx;
  logic [IDX-1:0]      ex_idx;
  ctr_t                f_ctr;
  logic                btb_hit;
  logic [XLEN-1:0]     btb_target;
  logic                bht_we;
  logic [IDX-1:0]      bht_waddr;
  ctr_t                bht_wdata;
  logic                btb_we;
  logic                btb_clr;
  logic [BIDX-1:0]     btb_clr_idx;
  logic [XLEN-1:0]     f_seq_pc;
  logic [XLEN-1:0]     ex_seq_pc;

  bp_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .lk_pc_word (f_pc[XLEN-1:2]),
    .lk_hit     (btb_hit),
    .lk_target  (btb_target),
    .wr_en      (btb_we),
    .wr_pc_word (ex_pc[XLEN-1:2]),
    .wr_target  (ex_target),
    .clr_en     (btb_clr),
    .clr_idx    (btb_clr_idx)
  );

  // Fetch-side prediction and execute-side mispredict detection.
  always_comb begin
    run       = (state_q == ST_RUN);
    f_idx     = IDX'(bp_index(32'(f_pc[XLEN-1:2]), 32'(ghr_q), USE_GSHARE));
    ex_idx    = IDX'(bp_index(32'(ex_pc[XLEN-1:2]), 32'(ex_ghr), USE_GSHARE));
    f_ctr     = bht_q[f_idx];
    f_seq_pc  = f_pc + XLEN'(3'd4);
    ex_seq_pc = ex_pc + XLEN'(3'd4);

    f_pred_taken  = run && btb_hit && ((f_ctr == WT) || (f_ctr == ST));
    f_pred_target = f_pred_taken ? btb_target : f_seq_pc;
    f_ghr         = ghr_q;

    resolve = run && ex_valid && ex_is_branch;
    mispred = (ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target));
    flush   = resolve && mispred;
    if (flush) begin
      redirect_pc = ex_taken ? ex_target : ex_seq_pc;
    end else begin
      redirect_pc = {XLEN{1'b0}};
    end

    ready         = run;
    stat_branches = stat_branches_q;
    stat_mispred  = stat_mispred_q;
  end

  // Sweep FSM and table write selection: the sweep owns the write ports in INIT.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    bht_we      = 1'b0;
    bht_waddr   = ex_idx;
    bht_wdata   = sat_update(bht_q[ex_idx], ex_taken);
    btb_we      = 1'b0;
    btb_clr     = 1'b0;
    btb_clr_idx = sweep_idx_q[BIDX-1:0];
    case (state_q)
      ST_INIT: begin
        sweep_idx_d = sweep_idx_q + SW'(1'b1);
        bht_we      = (32'(sweep_idx_q) < BHT_ENTRIES);
        bht_waddr   = sweep_idx_q[IDX-1:0];
        bht_wdata   = WNT;
        btb_clr     = (32'(sweep_idx_q) < BTB_ENTRIES);
        if (sweep_idx_q == SW'(SWEEP - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        bht_we = resolve;
        btb_we = resolve && ex_taken;
      end
      default: begin
        state_d     = ST_INIT;
        sweep_idx_d = {SW{1'b0}};
      end
    endcase
  end

  // History update (repair beats speculation) and saturating statistics.
  always_comb begin
    if (resolve && mispred) begin
      ghr_d = {ex_ghr[GHR_BITS-2:0], ex_taken};
    end else if (run && f_valid && btb_hit) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], f_pred_taken};
    end else begin
      ghr_d = ghr_q;
    end

    if (resolve && (stat_branches_q != 32'hFFFF_FFFF)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end else begin
      stat_branches_d = stat_branches_q;
    end

    if (flush && (stat_mispred_q != 32'hFFFF_FFFF)) begin
      stat_mispred_d = stat_mispred_q + 32'd1;
    end else begin
      stat_mispred_d = stat_mispred_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_INIT;
      sweep_idx_q     <= {SW{1'b0}};
      ghr_q           <= {GHR_BITS{1'b0}};
      stat_branches_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else begin
      state_q         <= state_d;
      sweep_idx_q     <= sweep_idx_d;
      ghr_q           <= ghr_d;
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  // Counter table; left to the sweep for initialisation rather than reset.
  always_ff @(posedge clk) begin
    if (!rst && bht_we) begin
      bht_q[bht_waddr] <= bht_wdata;
    end
  end

endmodule

// File: tb/tb_bp_gshare_predictor.sv
// Directed bench: a bimodal and a gshare instance share stimulus; a vector table
// plus hand sequences for sweep timing, GHR repair and mid-stream reset.
module tb_bp_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic [7:0]  ex_ghr;

  logic        b_pt, g_pt, b_ready, g_ready, b_flush, g_flush;
  logic [31:0] b_ptgt, g_ptgt, b_redir, g_redir;
  logic [31:0] b_sb, g_sb, b_sm, g_sm;
  logic [7:0]  b_ghr, g_ghr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bp_gshare_predictor #(.MODE(0)) u_bim (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
    .f_pred_taken(b_pt), .f_pred_target(b_ptgt), .f_ghr(b_ghr),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_ghr(ex_ghr),
    .ready(b_ready), .flush(b_flush), .redirect_pc(b_redir),
    .stat_branches(b_sb), .stat_mispred(b_sm)
  );

  bp_gshare_predictor #(.MODE(1)) u_gsh (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc),
    .f_pred_taken(g_pt), .f_pred_target(g_ptgt), .f_ghr(g_ghr),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_ghr(ex_ghr),
    .ready(g_ready), .flush(g_flush), .redirect_pc(g_redir),
    .stat_branches(g_sb), .stat_mispred(g_sm)
  );

  typedef struct {
    logic        fv;
    logic [31:0] fpc;
    logic        ev, eb;
    logic [31:0] epc;
    logic        et;
    logic [31:0] etg;
    logic        ept;
    logic [31:0] eptg;
    logic        xfl;
    logic [31:0] xrd;
    logic        xbt;
    logic [31:0] xbtg;
    logic        xgt;
    logic [31:0] xgtg;
    logic [7:0]  xghr;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic fv, input logic [31:0] fpc,
                              input logic ev, input logic eb, input logic [31:0] epc,
                              input logic et, input logic [31:0] etg,
                              input logic ept, input logic [31:0] eptg,
                              input logic xfl, input logic [31:0] xrd,
                              input logic xbt, input logic [31:0] xbtg,
                              input logic xgt, input logic [31:0] xgtg,
                              input logic [7:0] xghr);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.ev = ev; v.eb = eb; v.epc = epc;
    v.et = et; v.etg = etg; v.ept = ept; v.eptg = eptg;
    v.xfl = xfl; v.xrd = xrd; v.xbt = xbt; v.xbtg = xbtg;
    v.xgt = xgt; v.xgtg = xgtg; v.xghr = xghr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input logic ev, input logic eb, input logic [31:0] epc,
                          input logic et, input logic [31:0] etg,
                          input logic ept, input logic [31:0] eptg, input logic [7:0] eg);
    ex_valid = ev; ex_is_branch = eb; ex_pc = epc; ex_taken = et;
    ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg; ex_ghr = eg;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!(b_ready && g_ready) && (n < 400)) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int cycles;

  initial begin
    vecs[0]  = mk(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 1'b1, 32'h400, 1'b0, 32'h104, 1'b0, 32'h104, 8'h00);
    vecs[1]  = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h204, 8'h01);
    vecs[2]  = mk(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400, 1'b1, 32'h400, 1'b1, 32'h204, 1'b1, 32'h400, 1'b0, 32'h204, 8'h02);
    vecs[3]  = mk(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400, 1'b0, 32'h204, 1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h204, 8'h00);
    vecs[4]  = mk(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400, 1'b0, 32'h204, 1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h204, 8'h00);
    vecs[5]  = mk(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400, 1'b0, 32'h204, 1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h204, 8'h00);
    vecs[6]  = mk(1'b1, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 1'b1, 32'h400, 1'b0, 32'h204, 1'b0, 32'h204, 8'h00);
    vecs[7]  = mk(1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h204, 1'b0, 32'h204, 8'h01);
    vecs[8]  = mk(1'b0, 32'h300, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 32'h304, 1'b0, 32'h304, 8'h02);
    vecs[9]  = mk(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h204, 8'h02);
    vecs[10] = mk(1'b0, 32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h204, 8'h01);
    vecs[11] = mk(1'b0, 32'h240, 1'b1, 1'b1, 32'h240, 1'b1, 32'h900, 1'b0, 32'h244, 1'b1, 32'h900, 1'b0, 32'h244, 1'b0, 32'h244, 8'h01);
    vecs[12] = mk(1'b0, 32'h240, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h900, 1'b0, 32'h244, 8'h01);
    vecs[13] = mk(1'b0, 32'h300, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 32'h304, 1'b0, 32'h304, 8'h01);
    vecs[14] = mk(1'b0, 32'h300, 1'b1, 1'b1, 32'h200, 1'b0, 32'h400, 1'b1, 32'h400, 1'b1, 32'h204, 1'b0, 32'h304, 1'b0, 32'h304, 8'h01);
    vecs[15] = mk(1'b0, 32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b1, 32'h400, 8'h00);

    // Reset, with a mispredicting resolve held active that INIT must ignore.
    rst = 1'b1; f_valid = 1'b1; f_pc = 32'h100;
    drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(b_ready), 32'd0);
    check("rst_flush", 32'(b_flush), 32'd0);
    check("rst_redirect", b_redir, 32'd0);
    check("rst_ghr", 32'(g_ghr), 32'd0);
    check("rst_stat_br", b_sb, 32'd0);
    check("rst_pred_taken", 32'(b_pt), 32'd0);
    check("rst_pred_target", b_ptgt, 32'h104);
    wait_ready(cycles);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
    f_valid = 1'b0;
    check("sweep_cycles", 32'(cycles), 32'd256);
    #1;
    check("init_stat_br", g_sb, 32'd0);
    check("init_stat_mp", g_sm, 32'd0);

    // Vector table.
    for (int i = 0; i < 16; i++) begin
      f_valid = vecs[i].fv; f_pc = vecs[i].fpc;
      drive_ex(vecs[i].ev, vecs[i].eb, vecs[i].epc, vecs[i].et, vecs[i].etg,
               vecs[i].ept, vecs[i].eptg, 8'h00);
      #1;
      check($sformatf("v%0d flush_b", i), 32'(b_flush), 32'(vecs[i].xfl));
      check($sformatf("v%0d flush_g", i), 32'(g_flush), 32'(vecs[i].xfl));
      check($sformatf("v%0d redirect", i), b_redir, vecs[i].xrd);
      check($sformatf("v%0d taken_b", i), 32'(b_pt), 32'(vecs[i].xbt));
      check($sformatf("v%0d target_b", i), b_ptgt, vecs[i].xbtg);
      check($sformatf("v%0d taken_g", i), 32'(g_pt), 32'(vecs[i].xgt));
      check($sformatf("v%0d target_g", i), g_ptgt, vecs[i].xgtg);
      check($sformatf("v%0d ghr_g", i), 32'(g_ghr), 32'(vecs[i].xghr));
      @(posedge clk); #1;
    end
    f_valid = 1'b0;
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
    #1;
    check("tbl_stat_br_b", b_sb, 32'd11);
    check("tbl_stat_mp_b", b_sm, 32'd6);
    check("tbl_stat_br_g", g_sb, 32'd11);
    check("tbl_stat_mp_g", g_sm, 32'd6);

    // GHR repair beats a same-cycle speculative shift from a fetch BTB hit.
    f_valid = 1'b1; f_pc = 32'h200;
    drive_ex(1'b1, 1'b1, 32'h204, 1'b1, 32'h800, 1'b0, 32'h208, 8'h5A);
    #1;
    check("repair_flush", 32'(g_flush), 32'd1);
    check("repair_redirect", g_redir, 32'h800);
    @(posedge clk); #1;
    f_valid = 1'b0;
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
    #1;
    check("repair_ghr_g", 32'(g_ghr), 32'h0B5);
    check("repair_ghr_b", 32'(b_ghr), 32'h0B5);
    check("repair_stat_br", b_sb, 32'd12);
    check("repair_stat_mp", b_sm, 32'd7);

    // Reset mid-stream: stats, history and BTB all return to initial state.
    f_pc = 32'h200;
    drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(g_ready), 32'd0);
    check("mid_rst_flush", 32'(b_flush), 32'd0);
    check("mid_rst_stat_br", b_sb, 32'd0);
    check("mid_rst_stat_mp", b_sm, 32'd0);
    check("mid_rst_ghr", 32'(g_ghr), 32'd0);
    check("mid_rst_taken", 32'(b_pt), 32'd0);
    wait_ready(cycles);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
    check("mid_sweep_cycles", 32'(cycles), 32'd256);
    #1;
    check("post_taken_b", 32'(b_pt), 32'd0);
    check("post_target_b", b_ptgt, 32'h204);
    check("post_stat_br", g_sb, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
